// File: rtl/mem_port_arbiter_if.sv
// Shared memory bus between the arbiter (master) and the memory system (slave).
// The handshake is request, address accept, then data complete.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              bus_req;
    logic              bus_wr;
    logic [3:0]        bus_sel;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_addr_ok;
    logic              bus_data_ok;
    logic [DATA_W-1:0] bus_rdata;

    modport master (
        output bus_req, bus_wr, bus_sel, bus_addr, bus_wdata,
        input  bus_addr_ok, bus_data_ok, bus_rdata
    );

    modport slave (
        input  bus_req, bus_wr, bus_sel, bus_addr, bus_wdata,
        output bus_addr_ok, bus_data_ok, bus_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch port and the data port of the pipeline onto one memory bus.
// Data has priority, and a starvation counter forces a fetch grant after STARVE_MAX data grants.
//   state  | meaning
//   S_IDLE | no transaction; arbitrate and latch the winner's request
//   S_ADDR | bus_req high, waiting for bus_addr_ok
//   S_DATA | address accepted, waiting for bus_data_ok
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_cancel,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_done,
    output logic              i_stall,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [3:0]        d_sel,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              d_stall,
    mem_port_arbiter_if.master bus
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} stateType;
    typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_DATA} ownerType;

    stateType          stateQ, stateD;
    ownerType          ownerQ;
    logic [ADDR_W-1:0] addrQ;
    logic              wrQ;
    logic [3:0]        selQ;
    logic [DATA_W-1:0] wdataQ;
    logic [CNT_W-1:0]  starveQ;
    logic              dropQ;
    logic [DATA_W-1:0] iRdataQ, dRdataQ;
    logic              iDoneQ, dDoneQ;

    logic              iElig, dElig, settle;
    logic              grantData, grantFetch, complete, fetchDrop;

    assign iElig     = i_req & ~iDoneQ;
    assign dElig     = d_req & ~dDoneQ;
    // Nothing is granted in a done cycle: both ports see their done before re-requesting.
    assign settle    = iDoneQ | dDoneQ;
    assign fetchDrop = dropQ | i_cancel;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) stateQ <= S_IDLE;
        else      stateQ <= stateD;
    end

    always_comb begin
        stateD     = stateQ;
        grantData  = 1'b0;
        grantFetch = 1'b0;
        complete   = 1'b0;
        case (stateQ)
            S_IDLE: begin
                if (!settle) begin
                    if (dElig && !(starveQ == CNT_MAX && iElig)) grantData = 1'b1;
                    else if (iElig)                              grantFetch = 1'b1;
                end
                if (grantData || grantFetch) stateD = S_ADDR;
            end
            S_ADDR: begin
                if (bus.bus_addr_ok) begin
                    if (bus.bus_data_ok) begin
                        complete = 1'b1;
                        stateD   = S_IDLE;
                    end else begin
                        stateD = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (bus.bus_data_ok) begin
                    complete = 1'b1;
                    stateD   = S_IDLE;
                end
            end
            default: stateD = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ownerQ  <= OWN_NONE;
            addrQ   <= '0;
            wrQ     <= 1'b0;
            selQ    <= 4'b0000;
            wdataQ  <= '0;
            starveQ <= '0;
            dropQ   <= 1'b0;
            iRdataQ <= '0;
            dRdataQ <= '0;
            iDoneQ  <= 1'b0;
            dDoneQ  <= 1'b0;
        end else begin
            if (grantData) begin
                ownerQ <= OWN_DATA;
                addrQ  <= d_addr;
                wrQ    <= d_wr;
                selQ   <= d_sel;
                wdataQ <= d_wdata;
            end else if (grantFetch) begin
                ownerQ <= OWN_FETCH;
                addrQ  <= i_addr;
                wrQ    <= 1'b0;
                selQ   <= 4'b1111;
                wdataQ <= '0;
            end else if (complete) begin
                ownerQ <= OWN_NONE;
            end

            if (!i_req || grantFetch)                  starveQ <= '0;
            else if (grantData && starveQ != CNT_MAX) starveQ <= starveQ + 1'b1;

            if (complete)                                dropQ <= 1'b0;
            else if (i_cancel && ownerQ == OWN_FETCH)    dropQ <= 1'b1;

            iDoneQ <= complete && ownerQ == OWN_FETCH && !fetchDrop;
            dDoneQ <= complete && ownerQ == OWN_DATA;

            if (complete && ownerQ == OWN_FETCH && !fetchDrop) iRdataQ <= bus.bus_rdata;
            if (complete && ownerQ == OWN_DATA && !wrQ)        dRdataQ <= bus.bus_rdata;
        end
    end

    assign bus.bus_req   = (stateQ == S_ADDR);
    assign bus.bus_wr    = wrQ;
    assign bus.bus_sel   = selQ;
    assign bus.bus_addr  = addrQ;
    assign bus.bus_wdata = wdataQ;

    assign i_rdata = iRdataQ;
    assign i_done  = iDoneQ;
    assign d_rdata = dRdataQ;
    assign d_done  = dDoneQ;
    // Stalls are held low while in reset so every output reads zero.
    assign i_stall = rst & i_req & ~iDoneQ;
    assign d_stall = rst & d_req & ~dDoneQ;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a latency-programmable bus slave.
// Expected values are hand-computed constants.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_cancel = 1'b0;
    logic [31:0] i_rdata;
    logic        i_done, i_stall;
    logic        d_req = 1'b0;
    logic        d_wr = 1'b0;
    logic [3:0]  d_sel = 4'h0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_done, d_stall;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_cancel(i_cancel),
        .i_rdata(i_rdata), .i_done(i_done), .i_stall(i_stall),
        .d_req(d_req), .d_wr(d_wr), .d_sel(d_sel), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
        .bus(bus)
    );

    int nChecks = 0;
    int nFails  = 0;

    int          addrDelay = 0;
    int          dataDelay = 1;
    logic [31:0] slvRdata = '0;
    logic [35:0] grantLog[$];

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Bus slave: addr_ok after addrDelay cycles of bus_req, data_ok dataDelay cycles later.
    initial begin
        int ph;
        int wt;
        ph = 0;
        wt = 0;
        bus.bus_addr_ok = 1'b0;
        bus.bus_data_ok = 1'b0;
        bus.bus_rdata   = '0;
        forever begin
            @(negedge clk);
            bus.bus_addr_ok = 1'b0;
            bus.bus_data_ok = 1'b0;
            if (!rst) begin
                ph = 0;
                wt = 0;
            end else if (ph == 0) begin
                if (bus.bus_req) begin
                    if (wt == 0) grantLog.push_back({bus.bus_sel, bus.bus_addr});
                    if (wt >= addrDelay) begin
                        bus.bus_addr_ok = 1'b1;
                        wt = 0;
                        if (dataDelay == 0) begin
                            bus.bus_data_ok = 1'b1;
                            bus.bus_rdata   = slvRdata;
                        end else begin
                            ph = 1;
                        end
                    end else begin
                        wt++;
                    end
                end
            end else begin
                wt++;
                if (wt >= dataDelay) begin
                    bus.bus_data_ok = 1'b1;
                    bus.bus_rdata   = slvRdata;
                    ph = 0;
                    wt = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] expOrder[7];
        logic        dSeen, iSeen, sawDone;
        int          dAt, iAt, dCnt;

        repeat (3) @(negedge clk);
        checkVal("rst_ctrl", {bus.bus_req, bus.bus_wr, bus.bus_sel, i_done, d_done, i_stall, d_stall}, 0);
        checkVal("rst_addr", bus.bus_addr, 0);
        checkVal("rst_rdata", {i_rdata, d_rdata}, 0);
        rst = 1'b1;
        @(negedge clk);

        // Fetch only: addr_ok in cycle 1, data_ok in cycle 2, done in cycle 3
        addrDelay = 0; dataDelay = 1; slvRdata = 32'h3C010001;
        i_addr = 32'hBFC00000; i_req = 1'b1;
        @(negedge clk);
        checkVal("t1_busreq", bus.bus_req, 1);
        checkVal("t1_busaddr", bus.bus_addr, 32'hBFC00000);
        checkVal("t1_bussel", bus.bus_sel, 4'hF);
        checkVal("t1_stall", i_stall, 1);
        @(negedge clk);
        checkVal("t1_busreq_data", bus.bus_req, 0);
        checkVal("t1_done_early", i_done, 0);
        @(negedge clk);
        checkVal("t1_done", i_done, 1);
        checkVal("t1_rdata", i_rdata, 32'h3C010001);
        checkVal("t1_stall_done", i_stall, 0);
        i_req = 1'b0;
        @(negedge clk);
        checkVal("t1_done_pulse", i_done, 0);

        // Same-cycle addr_ok and data_ok: DATA skipped, done in cycle 2
        addrDelay = 0; dataDelay = 0; slvRdata = 32'h8C220004;
        d_addr = 32'h40; d_wr = 1'b0; d_sel = 4'hF; d_req = 1'b1;
        @(negedge clk);
        checkVal("t5_busreq", bus.bus_req, 1);
        checkVal("t5_busaddr", bus.bus_addr, 32'h40);
        @(negedge clk);
        checkVal("t5_done", d_done, 1);
        checkVal("t5_rdata", d_rdata, 32'h8C220004);
        checkVal("t5_busreq_after", bus.bus_req, 0);
        d_req = 1'b0;
        @(negedge clk);

        // Simultaneous requests: store first, then fetch
        grantLog.delete();
        addrDelay = 0; dataDelay = 1; slvRdata = 32'h24420001;
        i_addr = 32'hBFC00004;
        d_wr = 1'b1; d_sel = 4'b0011; d_addr = 32'h10; d_wdata = 32'hABCD;
        i_req = 1'b1; d_req = 1'b1;
        @(negedge clk);
        checkVal("t2_sel", bus.bus_sel, 4'b0011);
        checkVal("t2_wr", bus.bus_wr, 1);
        checkVal("t2_addr", bus.bus_addr, 32'h10);
        checkVal("t2_wdata", bus.bus_wdata, 32'hABCD);
        dSeen = 1'b0; iSeen = 1'b0; dAt = 0; iAt = 0;
        for (int k = 0; k < 30 && !(dSeen && iSeen); k++) begin
            @(negedge clk);
            if (d_done) begin
                dSeen = 1'b1; dAt = k; d_req = 1'b0;
                checkVal("t2_store_keeps_rdata", d_rdata, 32'h8C220004);
            end
            if (i_done) begin
                iSeen = 1'b1; iAt = k; i_req = 1'b0;
                checkVal("t2_fetch_rdata", i_rdata, 32'h24420001);
            end
        end
        checkVal("t2_both_done", {dSeen, iSeen}, 2'b11);
        checkVal("t2_order", dAt < iAt, 1);
        checkVal("t2_fetch_grant", grantLog.size() > 1 ? grantLog[1] : 36'h0, {4'hF, 32'hBFC00004});
        @(negedge clk);

        // Starvation: six loads against a waiting fetch
        grantLog.delete();
        addrDelay = 0; dataDelay = 1; slvRdata = 32'h11112222;
        i_addr = 32'h100; d_addr = 32'h200; d_wr = 1'b0; d_sel = 4'hF;
        i_req = 1'b1; d_req = 1'b1;
        dCnt = 0; iSeen = 1'b0;
        for (int k = 0; k < 200 && !(dCnt == 6 && iSeen); k++) begin
            @(negedge clk);
            if (d_done) begin
                dCnt++;
                if (dCnt == 6) d_req = 1'b0;
            end
            if (i_done) begin
                iSeen = 1'b1; i_req = 1'b0;
            end
        end
        checkVal("t3_dcount", dCnt, 6);
        checkVal("t3_fetch_done", iSeen, 1);
        checkVal("t3_ngrants", grantLog.size(), 7);
        expOrder = '{32'h200, 32'h200, 32'h200, 32'h200, 32'h100, 32'h200, 32'h200};
        for (int k = 0; k < 7 && k < grantLog.size(); k++)
            checkVal($sformatf("t3_grant%0d", k), grantLog[k][31:0], expOrder[k]);
        @(negedge clk);

        // Cancel during DATA: no i_done, i_rdata unchanged
        addrDelay = 0; dataDelay = 3; slvRdata = 32'h1234;
        i_addr = 32'h300; i_req = 1'b1;
        @(negedge clk);
        checkVal("t4_busreq", bus.bus_req, 1);
        @(negedge clk);
        i_cancel = 1'b1; i_req = 1'b0;
        @(negedge clk);
        i_cancel = 1'b0;
        sawDone = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (i_done) sawDone = 1'b1;
        end
        checkVal("t4_no_done", sawDone, 0);
        checkVal("t4_rdata_kept", i_rdata, 32'h11112222);
        checkVal("t4_bus_idle", bus.bus_req, 0);
        addrDelay = 0; dataDelay = 0; slvRdata = 32'h5555AAAA;
        d_addr = 32'h44; d_wr = 1'b0; d_req = 1'b1;
        @(negedge clk);
        checkVal("t4_idle_grant", bus.bus_req, 1);
        @(negedge clk);
        checkVal("t4_idle_done", d_done, 1);
        checkVal("t4_idle_rdata", d_rdata, 32'h5555AAAA);
        d_req = 1'b0;
        @(negedge clk);

        // Asynchronous reset while in DATA
        addrDelay = 0; dataDelay = 5; slvRdata = 32'hCAFEF00D;
        d_addr = 32'h80; d_wr = 1'b1; d_sel = 4'hF; d_wdata = 32'hDEADBEEF; d_req = 1'b1;
        @(negedge clk);
        checkVal("t6_busreq", bus.bus_req, 1);
        checkVal("t6_buswr", bus.bus_wr, 1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checkVal("t6_rst_ctrl", {bus.bus_req, bus.bus_wr, bus.bus_sel, i_done, d_done, i_stall, d_stall}, 0);
        checkVal("t6_rst_bus", {bus.bus_addr, bus.bus_wdata}, 0);
        checkVal("t6_rst_rdata", {i_rdata, d_rdata}, 0);
        @(negedge clk);
        @(negedge clk);
        addrDelay = 0; dataDelay = 0;
        d_addr = 32'h84; d_wr = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checkVal("t6_regrant", bus.bus_req, 1);
        checkVal("t6_regrant_addr", bus.bus_addr, 32'h84);
        @(negedge clk);
        checkVal("t6_done", d_done, 1);
        checkVal("t6_rdata", d_rdata, 32'hCAFEF00D);
        d_req = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end

endmodule
